// File: rtl/instr_cache_refill.sv
// instr_cache_refill -- miss handling and line refill engine for the
// instruction cache core.
//
// On a fetch miss the engine stalls fetch, reads one cache line from the
// memory port as WORDS words of DSIZE bits over a req/ack handshake,
// assembles them into a BSIZE-bit block (word 0 at the MSBs) and writes the
// block into the cache core with a one-cycle bwrite pulse. SYS aborts any
// refill in progress.
//
// Optional feature (compile-time macro ICACHE_CRITICAL_WORD_FIRST_EN):
//   the refill starts at the missed word and wraps within the line; the
//   missed word is also forwarded on crit_valid/crit_data as it arrives.
//
// Ports:
//   CLK         in   clock, rising edge
//   RESET       in   asynchronous reset, active low
//   SYS         in   synchronous flush/abort
//   fetch_req   in   fetch stage requests an instruction at fetch_addr
//   fetch_addr  in   fetch byte address
//   hit         in   hit indication from the cache core for core_addr
//   core_addr   out  address to the cache core
//   bwrite      out  block write strobe to the cache core
//   block_out   out  assembled line to the cache core
//   stall       out  freeze fetch
//   mem_req     out  memory word request
//   mem_addr    out  word address being requested
//   mem_ack     in   memory word valid this cycle
//   mem_data    in   memory read data
//   crit_valid  out  (feature only) critical word accepted this cycle
//   crit_data   out  (feature only) critical word data

module instr_cache_refill #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 32,
    parameter int BBITS = 5,
    parameter int BSIZE = 8 << BBITS,
    parameter int WORDS = BSIZE / DSIZE
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             SYS,
    input  logic             fetch_req,
    input  logic [ASIZE-1:0] fetch_addr,
    input  logic             hit,
    output logic [ASIZE-1:0] core_addr,
    output logic             bwrite,
    output logic [BSIZE-1:0] block_out,
    output logic             stall,
    output logic             mem_req,
    output logic [ASIZE-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [DSIZE-1:0] mem_data
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    ,
    output logic             crit_valid,
    output logic [DSIZE-1:0] crit_data
`endif
);

    localparam int CW = $clog2(WORDS);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [CW-1:0]    start;
    logic [CW-1:0]    slot;
    logic [ASIZE-1:0] miss_addr;
    logic [BSIZE-1:0] buffer;
    logic             miss;
    logic             accept;

    assign miss   = fetch_req && !hit;
    // Slot index wraps naturally in CW bits (modulo WORDS).
    assign slot   = start + count;
    // A word is only taken while filling and not being flushed.
    assign accept = (state == FILL) && mem_ack && !SYS;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        core_addr  = fetch_addr;
        bwrite     = 1'b0;
        stall      = 1'b0;
        mem_req    = 1'b0;
        if (SYS) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (miss) state_next = FILL;
                FILL:    if (mem_ack && count == LAST) state_next = WRITE;
                WRITE:   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
        case (state)
            IDLE: begin
                stall = miss;
            end
            FILL: begin
                stall   = 1'b1;
                mem_req = 1'b1;
            end
            WRITE: begin
                stall     = 1'b1;
                bwrite    = 1'b1;
                core_addr = miss_addr;
            end
            default: ;
        endcase
    end

    // miss_addr has its offset bits cleared, so the word address is a
    // concatenation rather than an add.
    assign mem_addr  = {miss_addr[ASIZE-1:BBITS], slot, 2'b00};
    assign block_out = buffer;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    assign crit_valid = accept && (count == '0);
    assign crit_data  = mem_data;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count     <= '0;
            start     <= '0;
            miss_addr <= '0;
            buffer    <= '0;
        end else if (SYS) begin
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        miss_addr <= {fetch_addr[ASIZE-1:BBITS], {BBITS{1'b0}}};
                        count     <= '0;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
                        start     <= fetch_addr[BBITS-1:2];
`else
                        start     <= '0;
`endif
                    end
                end
                FILL: begin
                    if (accept) begin
                        for (int unsigned i = 0; i < WORDS; i++) begin
                            if (slot == i[CW-1:0]) begin
                                buffer[BSIZE-1-i*DSIZE -: DSIZE] <= mem_data;
                            end
                        end
                        count <= count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_cache_refill.sv
// Testbench for instr_cache_refill: directed miss/refill scenarios with a
// scoreboard. Stimulus pushes expected word addresses, blocks and critical
// words into queues; a monitor pops and compares whenever the DUT accepts a
// word, pulses bwrite or flags a critical word.
// Memory model returns 0xA0 + word index for every word address.

module tb_instr_cache_refill;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic         SYS = 1'b0;
    logic         fetch_req = 1'b0;
    logic [31:0]  fetch_addr = '0;
    logic         hit = 1'b0;
    logic [31:0]  core_addr;
    logic         bwrite;
    logic [255:0] block_out;
    logic         stall;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack = 1'b0;
    logic [31:0]  mem_data;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    logic         crit_valid;
    logic [31:0]  crit_data;
`endif

    instr_cache_refill #(
        .DSIZE(32),
        .ASIZE(32),
        .BBITS(5)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .SYS        (SYS),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .hit        (hit),
        .core_addr  (core_addr),
        .bwrite     (bwrite),
        .block_out  (block_out),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data)
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        ,
        .crit_valid (crit_valid),
        .crit_data  (crit_data)
`endif
    );

    always #5 CLK = ~CLK;

    assign mem_data = 32'hA0 + {29'd0, mem_addr[4:2]};

    int total = 0;
    int bad = 0;
    int bw_count = 0;
    int crit_count = 0;

    logic [31:0]  exp_addr_q[$];
    logic [255:0] exp_blk_q[$];
    logic [31:0]  exp_caddr_q[$];
    logic [31:0]  exp_crit_q[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] blk_a0;
        logic [255:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) b[255-32*i -: 32] = 32'hA0 + 32'(i);
        return b;
    endfunction

    task automatic push_line(input logic [31:0] line, input int first, input int n);
        for (int i = 0; i < n; i++)
            exp_addr_q.push_back(line + 32'(4 * ((first + i) % 8)));
    endtask

    // Monitor: compares every DUT-presented transfer against the scoreboard.
    always @(negedge CLK) begin
        if (RESET) begin
            if (mem_req && mem_ack) begin
                if (exp_addr_q.size() == 0) chk("unexpected_word", 1, 0);
                else chk("mem_addr", mem_addr, exp_addr_q.pop_front());
            end
            if (bwrite) begin
                bw_count++;
                if (exp_blk_q.size() == 0) chk("unexpected_bwrite", 1, 0);
                else begin
                    chk("block_out", block_out, exp_blk_q.pop_front());
                    chk("core_addr", core_addr, exp_caddr_q.pop_front());
                end
            end
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
            if (crit_valid) begin
                crit_count++;
                if (exp_crit_q.size() == 0) chk("unexpected_crit", 1, 0);
                else chk("crit_data", crit_data, exp_crit_q.pop_front());
            end
`endif
        end
    end

    // Called right after an edge with miss stimulus applied; returns the
    // number of negedges that passed before bwrite was seen.
    task automatic wait_bwrite(output int n);
        n = 0;
        @(negedge CLK);
        while (!bwrite && n < 40) begin
            chk("stall_during_miss", stall, 1);
            n++;
            @(negedge CLK);
        end
        if (!bwrite) chk("bwrite_timeout", 0, 1);
        else chk("stall_at_bwrite", stall, 1);
    endtask

    // Core reports hit for the refilled line in the cycle after WRITE.
    task automatic finish_refill;
        @(posedge CLK); #1;
        hit = 1'b1;
        @(negedge CLK);
        chk("stall_after_hit", stall, 0);
        @(posedge CLK); #1;
        fetch_req = 1'b0;
        hit = 1'b0;
    endtask

    initial begin
        int n;
        int acks;
        int bw0;
        logic [9:0] pat;

        // Reset state
        #2;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_bwrite", bwrite, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_stall_idle", stall, 0);
        fetch_req = 1'b1;
        #1;
        chk("rst_stall_miss", stall, 1);
        fetch_req = 1'b0;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        chk("rst_crit_valid", crit_valid, 0);
`endif
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;

        // Miss with acks every cycle
        push_line(32'h1040, 0, 8);
        exp_blk_q.push_back(blk_a0());
        exp_caddr_q.push_back(32'h1040);
        bw0 = bw_count;
        fetch_addr = 32'h0000_1044;
        hit = 1'b0;
        fetch_req = 1'b1;
        mem_ack = 1'b1;
        wait_bwrite(n);
        chk("bwrite_latency", n, 9);
        chk("mem_req_in_write", mem_req, 0);
        mem_ack = 1'b0;
        finish_refill();
        chk("one_bwrite_t1", bw_count - bw0, 1);

        // Miss with ack gaps
        push_line(32'h1040, 0, 8);
        exp_blk_q.push_back(blk_a0());
        exp_caddr_q.push_back(32'h1040);
        bw0 = bw_count;
        fetch_addr = 32'h0000_1044;
        fetch_req = 1'b1;
        mem_ack = 1'b0;
        @(posedge CLK); #1;
        pat = 10'b1001101111;
        acks = 0;
        for (int i = 0; i < 30; i++) begin
            mem_ack = (i < 10) ? pat[9-i] : 1'b1;
            @(negedge CLK);
            if (bwrite) break;
            if (!mem_ack) begin
                chk("hold_mem_addr", mem_addr, 32'h1040 + 32'(4 * acks));
                chk("hold_mem_req", mem_req, 1);
            end else begin
                acks++;
            end
            @(posedge CLK); #1;
        end
        mem_ack = 1'b0;
        chk("gap_bwrite_seen", bwrite, 1);
        chk("gap_words", acks, 8);
        finish_refill();
        chk("one_bwrite_t2", bw_count - bw0, 1);

        // Hit path
        fetch_addr = 32'h0000_1050;
        fetch_req = 1'b1;
        hit = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("hit_path_quiet", {stall, mem_req, bwrite}, 3'b000);
        end
        @(posedge CLK); #1;
        fetch_req = 1'b0;
        hit = 1'b0;

        // SYS abort after the 3rd ack
        push_line(32'h1040, 0, 3);
        bw0 = bw_count;
        fetch_addr = 32'h0000_1044;
        fetch_req = 1'b1;
        mem_ack = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        SYS = 1'b1;
        mem_ack = 1'b0;
        fetch_req = 1'b0;
        @(negedge CLK);
        chk("pre_abort_mem_req", mem_req, 1);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("abort_mem_req", mem_req, 0);
        chk("abort_bwrite", bwrite, 0);
        chk("abort_stall", stall, 0);
        // SYS still high: a pending miss must not start a fill
        fetch_addr = 32'h0000_2000;
        fetch_req = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("sys_priority_mem_req", mem_req, 0);
        chk("no_bwrite_abort", bw_count - bw0, 0);
        @(posedge CLK); #1;
        SYS = 1'b0;
        push_line(32'h2000, 0, 8);
        exp_blk_q.push_back(blk_a0());
        exp_caddr_q.push_back(32'h2000);
        mem_ack = 1'b1;
        wait_bwrite(n);
        chk("restart_latency", n, 9);
        mem_ack = 1'b0;
        finish_refill();

        // Asynchronous reset after the 5th ack
        push_line(32'h1040, 0, 5);
        fetch_addr = 32'h0000_1044;
        fetch_req = 1'b1;
        mem_ack = 1'b1;
        repeat (6) @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        chk("async_mem_req", mem_req, 0);
        chk("async_bwrite", bwrite, 0);
        chk("async_mem_addr", mem_addr, 0);
        mem_ack = 1'b0;
        fetch_req = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        push_line(32'h1040, 0, 8);
        exp_blk_q.push_back(blk_a0());
        exp_caddr_q.push_back(32'h1040);
        fetch_req = 1'b1;
        mem_ack = 1'b1;
        wait_bwrite(n);
        chk("post_reset_latency", n, 9);
        mem_ack = 1'b0;
        finish_refill();

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        // Critical word first at 0x1058 (word 6)
        push_line(32'h1040, 6, 8);
        exp_blk_q.push_back(blk_a0());
        exp_caddr_q.push_back(32'h1040);
        exp_crit_q.push_back(32'hA6);
        n = crit_count;
        fetch_addr = 32'h0000_1058;
        fetch_req = 1'b1;
        mem_ack = 1'b1;
        begin
            int c0;
            c0 = n;
            wait_bwrite(n);
            chk("crit_pulses", crit_count - c0, 1);
        end
        chk("crit_latency", n, 9);
        mem_ack = 1'b0;
        finish_refill();
`endif

        repeat (2) @(posedge CLK);
        #1;
        chk("addr_queue_drained", exp_addr_q.size(), 0);
        chk("blk_queue_drained", exp_blk_q.size(), 0);
        chk("crit_queue_drained", exp_crit_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_cache_refill.md
Name: instr_cache_refill

Overview:
- Miss-handling and line-refill engine for the instruction cache core. It sits between the fetch stage and the cache core on one side and the 32-bit memory port on the other.
- On a fetch miss it stalls fetch and reads one full cache line as DSIZE-wide words over a req/ack handshake.
- It assembles the words into a BSIZE-bit block, then writes that block into the core with a one-cycle bwrite pulse.
- Flush (SYS) aborts any refill in progress.

Parameters:
- DSIZE, 32, word width of the fetch path and the memory data path.
- ASIZE, 32, address width.
- BBITS, 5, line offset bits; line = 1<<BBITS bytes.
- BSIZE, 8<<BBITS (256), block width driven to the core.
- WORDS, BSIZE/DSIZE (8), words per line; the word counter is log2(WORDS) bits.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  reset, asynchronous, active-low.
- SYS  in  1  synchronous flush/abort.
- fetch_req  in  1  fetch stage requests an instruction at fetch_addr.
- fetch_addr  in  ASIZE  fetch byte address.
- hit  in  1  hit1 from the cache core for core_addr.
- core_addr  out  ASIZE  address1 to the core.
- bwrite  out  1  block write strobe to the core.
- block_out  out  BSIZE  block_in to the core.
- stall  out  1  freeze fetch.
- mem_req  out  1  memory word request.
- mem_addr  out  ASIZE  word address being requested.
- mem_ack  in  1  memory word valid this cycle.
- mem_data  in  DSIZE  memory read data.

Behaviour:
- States: IDLE, FILL, WRITE. State is registered; outputs are decoded from state plus registers.
- Reset (RESET low, asynchronous) clears all registers at once, including mid-refill:
  - state=IDLE, count=0, miss_addr=0, block buffer=0.
  - bwrite=0, mem_req=0, mem_addr=0.
  - stall=fetch_req&~hit (combinational).
- core_addr:
  - equals fetch_addr in IDLE and FILL;
  - equals miss_addr in WRITE, so the core writes the missed line.
- IDLE:
  - stall = fetch_req & ~hit.
  - If fetch_req & ~hit at a rising edge:
    - miss_addr <= fetch_addr with its low BBITS bits forced to 0;
    - start word index <= 0;
    - count <= 0;
    - go to FILL.
  - fetch_req=0 means no action; hit is ignored.
- FILL:
  - stall=1 and mem_req=1.
  - mem_addr = miss_addr + 4*((start+count) mod WORDS).
  - Each cycle with mem_ack=1:
    - mem_data is written into word slot w=(start+count) mod WORDS;
    - slot w occupies block bits [BSIZE-1-w*DSIZE : BSIZE-(w+1)*DSIZE], so word 0 sits at the MSBs;
    - count increments.
  - mem_ack=0 means hold; mem_addr and mem_req stay stable.
  - The ack on count=WORDS-1 moves the block to WRITE.
- WRITE (exactly one cycle):
  - bwrite=1, stall=1, block_out = assembled buffer.
  - Next state is IDLE.
  - In the following cycle hit=1 for the refilled address, so stall drops with 2 cycles of latency after the last ack.
- block_out always reflects the buffer; it is only meaningful while bwrite=1.
- SYS=1 at a rising edge in any state:
  - state <= IDLE, count <= 0, no bwrite;
  - a partially filled buffer is discarded (contents don't-care).
  - mem_req drops the cycle after. Memory must tolerate an abandoned request; any mem_ack while in IDLE is ignored.
- SYS has priority over a pending miss in IDLE: no FILL entry in a cycle where SYS=1.
- Changing fetch_addr or fetch_req during FILL/WRITE has no effect; miss_addr is latched.
- count arithmetic is modulo WORDS; slot index wraps from WORDS-1 to 0.

Optional Feature:
- Macro: ICACHE_CRITICAL_WORD_FIRST_EN.
- When defined:
  - start <= fetch_addr[BBITS-1:2] on miss entry, so memory returns the missed word first and the address wraps within the line.
  - Additional output crit_valid (1 bit, reset 0) pulses for the one cycle in which the ack for count=0 is accepted.
  - Additional output crit_data (DSIZE) carries mem_data during that cycle, for early forwarding to fetch. stall behaviour is unchanged.
- When undefined:
  - start is forced to 0 and words are fetched in order 0..WORDS-1.
  - crit_valid and crit_data are absent.

Test Plan:
- Miss, acks every cycle:
  - Stimulus: reset, fetch_req=1, fetch_addr=0x0000_1044, hit=0; mem_ack=1 returning 0xA0..0xA7.
  - Required: mem_addr sequence 0x1040,0x1044,…,0x105C; bwrite=1 on the cycle after the 8th ack; core_addr=0x1040; block_out = 0x000000A0_…_000000A7 (A0 in MSBs); stall high from the miss cycle until hit returns.
- Ack with gaps:
  - Stimulus: same miss; mem_ack pattern 1,0,0,1,1,0,1,1,1,1.
  - Required: mem_addr held during the 0 cycles; exactly 8 words captured; exactly one bwrite pulse.
- Hit path:
  - Stimulus: fetch_req=1, hit=1 for 10 cycles.
  - Required: stall=0, mem_req=0, bwrite=0 throughout.
- SYS abort:
  - Stimulus: SYS=1 after the 3rd ack.
  - Required: state IDLE next cycle; mem_req=0; no bwrite; a following miss at 0x2000 restarts at mem_addr=0x2000.
- Async reset mid-FILL:
  - Stimulus: RESET low between clock edges after the 5th ack.
  - Required: mem_req and bwrite go 0 immediately, without waiting for a clock edge; after release, a miss restarts cleanly from count 0.
- With ICACHE_CRITICAL_WORD_FIRST_EN:
  - Stimulus: miss at 0x1058.
  - Required: mem_addr order 0x1058,0x105C,0x1040…0x1054; crit_valid pulses with the 0x1058 data; block slot ordering identical to the in-order case.
